shift_reg_univ: RTL

Parameterised universal shift register, the next generation of the team's fixed 4-bit serial-in register.
- Adds WIDTH generalisation, bidirectional shift, parallel load, clock enable, and a shift counter.
- Adds a one-cycle word_done strobe, so the block can double as a serial-to-parallel deserialiser.
- Sits between serial front-end logic and word-wide datapath consumers.

---
 rtl/shift_pkg.sv | 11 +
 rtl/shift_word_cnt.sv | 35 +++
 rtl/shift_reg_univ.sv | 59 +++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared constants for the universal shift register: mode encodings and default width.
package shift_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/shift_word_cnt.sv
// Wrap counter of completed shifts; raises word_done for one cycle after every WIDTH-th step.
module shift_word_cnt #(
  parameter int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             step,
  output logic [CNT_W-1:0] cnt,
  output logic             word_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  // word_done is a strobe, not a handshake: it is high for exactly the one
  // cycle following the edge that completed a word, with no back-pressure.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt       <= '0;
      word_done <= 1'b0;
    end else if (step) begin
      if (cnt == LAST) begin
        cnt       <= '0;
        word_done <= 1'b1;
      end else begin
        cnt       <= cnt + CNT_W'(1);
        word_done <= 1'b0;
      end
    end else begin
      word_done <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold, shift either way, parallel load, preset, with word counting.
module shift_reg_univ
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin_msb,
  input  logic             sin_lsb,
  input  logic [WIDTH-1:0] d_par,
  output logic [WIDTH-1:0] q,
  output logic             sout_lsb,
  output logic             sout_msb,
  output logic [CNT_W-1:0] cnt,
  output logic             word_done
);

  logic is_shift;
  logic is_load;
  logic cnt_clear;

  assign is_shift  = en && ((mode == MODE_SHR) || (mode == MODE_SHL));
  assign is_load   = en && (mode == MODE_LOAD);
  // A preset or load discards any partial word, so both restart the count.
  assign cnt_clear = set || is_load;

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (set) begin
      q <= '1;
    end else if (en) begin
      case (mode)
        MODE_SHR:  q <= {sin_msb, q[WIDTH-1:1]};
        MODE_SHL:  q <= {q[WIDTH-2:0], sin_lsb};
        MODE_LOAD: q <= d_par;
        default:   q <= q;
      endcase
    end
  end

  assign sout_lsb = q[0];
  assign sout_msb = q[WIDTH-1];

  shift_word_cnt #(.WIDTH(WIDTH)) u_word_cnt (
    .clk       (clk),
    .reset     (reset),
    .clear     (cnt_clear),
    .step      (is_shift),
    .cnt       (cnt),
    .word_done (word_done)
  );

endmodule
